// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, memory freeze,
// ALU operand forwarding selects and saturating stall/flush statistics.
module hazard_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic [4:0]       idex_rs_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             idex_mem_read_i,
  input  logic [4:0]       idex_write_register_i,
  input  logic             exmem_reg_write_i,
  input  logic [4:0]       exmem_write_register_i,
  input  logic             memwb_reg_write_i,
  input  logic [4:0]       memwb_write_register_i,
  input  logic             branch_taken_i,
  input  logic             jmp_i,
  input  logic             mem_busy_i,
  input  logic             counters_clr_i,
  output logic             pc_enable_o,
  output logic             ifid_enable_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic [1:0]       forward_a_o,
  output logic [1:0]       forward_b_o,
  output logic [1:0]       state_o,
  output logic             hazard_error_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FREEZE   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           r_state;
  logic             r_hazard_error;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  logic w_lu;
  logic w_rd;
  logic w_act_flush;
  logic w_act_stall;

  assign w_lu = idex_mem_read_i && (idex_write_register_i != 5'd0) &&
                ((idex_write_register_i == ifid_rs_i) ||
                 (ifid_uses_rt_i && (idex_write_register_i == ifid_rt_i)));
  assign w_rd = branch_taken_i || jmp_i;

  // Freeze masks both redirect and stall; redirect outranks a simultaneous load-use.
  assign w_act_flush = reset && !mem_busy_i && w_rd;
  assign w_act_stall = reset && !mem_busy_i && !w_rd && w_lu;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (exmem_reg_write_i && (exmem_write_register_i != 5'd0) &&
        (exmem_write_register_i == src))
      return 2'b10;
    else if (memwb_reg_write_i && (memwb_write_register_i != 5'd0) &&
             (memwb_write_register_i == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    pc_enable_o   = 1'b0;
    ifid_enable_o = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    forward_a_o   = 2'b00;
    forward_b_o   = 2'b00;
    if (reset) begin
      forward_a_o = fwd_sel(idex_rs_i);
      forward_b_o = fwd_sel(idex_rt_i);
      if (mem_busy_i) begin
        pc_enable_o   = 1'b0;
        ifid_enable_o = 1'b0;
      end else if (w_rd) begin
        pc_enable_o   = 1'b1;
        ifid_enable_o = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
      end else if (w_lu) begin
        idex_flush_o  = 1'b1;
      end else begin
        pc_enable_o   = 1'b1;
        ifid_enable_o = 1'b1;
      end
    end
  end

  // A second load-use hit while stalled means the bubble kept mem_read set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= RUN;
      r_hazard_error <= 1'b0;
      r_stall_count  <= '0;
      r_flush_count  <= '0;
    end else begin
      if (mem_busy_i)
        r_state <= FREEZE;
      else if (w_act_stall)
        r_state <= LU_STALL;
      else
        r_state <= RUN;

      if ((r_state == LU_STALL) && w_lu && !mem_busy_i)
        r_hazard_error <= 1'b1;

      if (counters_clr_i) begin
        r_stall_count <= '0;
        r_flush_count <= '0;
      end else begin
        if (w_act_stall && (r_stall_count != '1))
          r_stall_count <= r_stall_count + CNT_ONE;
        if (w_act_flush && (r_flush_count != '1))
          r_flush_count <= r_flush_count + CNT_ONE;
      end
    end
  end

  assign state_o        = r_state;
  assign hazard_error_o = r_hazard_error;
  assign stall_count_o  = r_stall_count;
  assign flush_count_o  = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: a rule-level model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_hazard_control_unit;

  typedef struct {
    logic [4:0] ifidRs, ifidRt;
    logic       ifidUsesRt;
    logic [4:0] idexRs, idexRt;
    logic       idexMemRead;
    logic [4:0] idexWr;
    logic       exmemRw;
    logic [4:0] exmemWr;
    logic       memwbRw;
    logic [4:0] memwbWr;
    logic       branchTaken, jmp, memBusy, countersClr;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ifidRs, ifidRt, idexRs, idexRt, idexWr, exmemWr, memwbWr;
  logic ifidUsesRt, idexMemRead, exmemRw, memwbRw;
  logic branchTaken, jmp, memBusy, countersClr;

  logic pcEn, ifidEn, ifidFlush, idexFlush, hazErr;
  logic [1:0] fwdA, fwdB, state;
  logic [15:0] stallCnt, flushCnt;

  logic sPcEn, sIfidEn, sIfidFlush, sIdexFlush, sHazErr;
  logic [1:0] sFwdA, sFwdB, sState;
  logic [1:0] sStallCnt, sFlushCnt;

  int errors = 0;
  int checks = 0;

  int mState, mErr, mStall16, mFlush16, mStallSat, mFlushSat;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs_i(ifidRs), .ifid_rt_i(ifidRt), .ifid_uses_rt_i(ifidUsesRt),
    .idex_rs_i(idexRs), .idex_rt_i(idexRt), .idex_mem_read_i(idexMemRead),
    .idex_write_register_i(idexWr),
    .exmem_reg_write_i(exmemRw), .exmem_write_register_i(exmemWr),
    .memwb_reg_write_i(memwbRw), .memwb_write_register_i(memwbWr),
    .branch_taken_i(branchTaken), .jmp_i(jmp), .mem_busy_i(memBusy),
    .counters_clr_i(countersClr),
    .pc_enable_o(pcEn), .ifid_enable_o(ifidEn),
    .ifid_flush_o(ifidFlush), .idex_flush_o(idexFlush),
    .forward_a_o(fwdA), .forward_b_o(fwdB), .state_o(state),
    .hazard_error_o(hazErr), .stall_count_o(stallCnt), .flush_count_o(flushCnt)
  );

  hazard_control_unit #(.CNT_W(2)) dutSat (
    .clk(clk), .reset(reset),
    .ifid_rs_i(ifidRs), .ifid_rt_i(ifidRt), .ifid_uses_rt_i(ifidUsesRt),
    .idex_rs_i(idexRs), .idex_rt_i(idexRt), .idex_mem_read_i(idexMemRead),
    .idex_write_register_i(idexWr),
    .exmem_reg_write_i(exmemRw), .exmem_write_register_i(exmemWr),
    .memwb_reg_write_i(memwbRw), .memwb_write_register_i(memwbWr),
    .branch_taken_i(branchTaken), .jmp_i(jmp), .mem_busy_i(memBusy),
    .counters_clr_i(countersClr),
    .pc_enable_o(sPcEn), .ifid_enable_o(sIfidEn),
    .ifid_flush_o(sIfidFlush), .idex_flush_o(sIdexFlush),
    .forward_a_o(sFwdA), .forward_b_o(sFwdB), .state_o(sState),
    .hazard_error_o(sHazErr), .stall_count_o(sStallCnt), .flush_count_o(sFlushCnt)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit modelLu();
    return idexMemRead && (idexWr != 0) &&
           ((idexWr == ifidRs) || (ifidUsesRt && (idexWr == ifidRt)));
  endfunction

  // Action codes: 0 reset, 2 freeze, 3 redirect, 4 load-use stall, 5 normal.
  function automatic int modelAction();
    if (!reset) return 0;
    if (memBusy) return 2;
    if (branchTaken || jmp) return 3;
    if (modelLu()) return 4;
    return 5;
  endfunction

  function automatic int modelFwd(input logic [4:0] src);
    if (!reset) return 0;
    if (exmemRw && (exmemWr != 0) && (exmemWr == src)) return 2;
    if (memwbRw && (memwbWr != 0) && (memwbWr == src)) return 1;
    return 0;
  endfunction

  function automatic int satInc(input int v, input int maxV);
    return (v < maxV) ? v + 1 : v;
  endfunction

  always @(posedge clk or negedge reset) begin
    int act;
    if (!reset) begin
      mState <= 0; mErr <= 0;
      mStall16 <= 0; mFlush16 <= 0; mStallSat <= 0; mFlushSat <= 0;
    end else begin
      act = modelAction();
      if (mState == 1 && modelLu() && !memBusy) mErr <= 1;
      mState <= memBusy ? 2 : ((act == 4) ? 1 : 0);
      if (countersClr) begin
        mStall16 <= 0; mFlush16 <= 0; mStallSat <= 0; mFlushSat <= 0;
      end else begin
        if (act == 4) begin
          mStall16  <= satInc(mStall16, 65535);
          mStallSat <= satInc(mStallSat, 3);
        end
        if (act == 3) begin
          mFlush16  <= satInc(mFlush16, 65535);
          mFlushSat <= satInc(mFlushSat, 3);
        end
      end
    end
  end

  always @(negedge clk) begin
    int act;
    act = modelAction();
    checkOutput("m_pc_enable",   pcEn,      (act == 3 || act == 5) ? 1 : 0);
    checkOutput("m_ifid_enable", ifidEn,    (act == 3 || act == 5) ? 1 : 0);
    checkOutput("m_ifid_flush",  ifidFlush, (act == 3) ? 1 : 0);
    checkOutput("m_idex_flush",  idexFlush, (act == 3 || act == 4) ? 1 : 0);
    checkOutput("m_forward_a",   fwdA,      modelFwd(idexRs));
    checkOutput("m_forward_b",   fwdB,      modelFwd(idexRt));
    checkOutput("m_state",       state,     mState);
    checkOutput("m_hazard_err",  hazErr,    mErr);
    checkOutput("m_stall_cnt",   stallCnt,  mStall16);
    checkOutput("m_flush_cnt",   flushCnt,  mFlush16);
    checkOutput("m_sat_stall",   sStallCnt, mStallSat);
    checkOutput("m_sat_flush",   sFlushCnt, mFlushSat);
  end

  function automatic stim_t idleStim();
    stim_t s;
    s.ifidRs = 0; s.ifidRt = 0; s.ifidUsesRt = 0;
    s.idexRs = 0; s.idexRt = 0; s.idexMemRead = 0; s.idexWr = 0;
    s.exmemRw = 0; s.exmemWr = 0; s.memwbRw = 0; s.memwbWr = 0;
    s.branchTaken = 0; s.jmp = 0; s.memBusy = 0; s.countersClr = 0;
    return s;
  endfunction

  // Drive a vector and move to the middle of the cycle where outputs are settled.
  task automatic applyStimulus(input stim_t s);
    ifidRs = s.ifidRs; ifidRt = s.ifidRt; ifidUsesRt = s.ifidUsesRt;
    idexRs = s.idexRs; idexRt = s.idexRt; idexMemRead = s.idexMemRead;
    idexWr = s.idexWr; exmemRw = s.exmemRw; exmemWr = s.exmemWr;
    memwbRw = s.memwbRw; memwbWr = s.memwbWr; branchTaken = s.branchTaken;
    jmp = s.jmp; memBusy = s.memBusy; countersClr = s.countersClr;
    @(negedge clk); #1;
  endtask

  task automatic nextEdge();
    @(posedge clk); #1;
  endtask

  initial begin
    stim_t s;
    stim_t lw8;
    reset = 1'b0;
    s = idleStim();
    applyStimulus(s);
    checkOutput("rst_pc_enable", pcEn, 0);
    checkOutput("rst_idex_flush", idexFlush, 0);
    nextEdge();
    checkOutput("rst_state", state, 0);
    checkOutput("rst_err", hazErr, 0);
    checkOutput("rst_stall", stallCnt, 0);
    checkOutput("rst_flush", flushCnt, 0);
    reset = 1'b1;

    applyStimulus(idleStim());
    checkOutput("idle_pc_enable", pcEn, 1);
    nextEdge();

    lw8 = idleStim();
    lw8.idexMemRead = 1; lw8.idexWr = 8; lw8.ifidRs = 8;
    applyStimulus(lw8);
    checkOutput("lu_pc_enable", pcEn, 0);
    checkOutput("lu_ifid_enable", ifidEn, 0);
    checkOutput("lu_idex_flush", idexFlush, 1);
    checkOutput("lu_ifid_flush", ifidFlush, 0);
    nextEdge();
    checkOutput("lu_state", state, 1);
    checkOutput("lu_stall_cnt", stallCnt, 1);
    applyStimulus(idleStim());
    checkOutput("bubble_pc_enable", pcEn, 1);
    checkOutput("bubble_ifid_enable", ifidEn, 1);
    nextEdge();
    checkOutput("bubble_state", state, 0);

    s = idleStim();
    s.idexMemRead = 1; s.idexWr = 0; s.ifidRs = 0;
    applyStimulus(s);
    checkOutput("r0_pc_enable", pcEn, 1);
    nextEdge();
    checkOutput("r0_stall_cnt", stallCnt, 1);

    s = idleStim();
    s.idexMemRead = 1; s.idexWr = 9; s.ifidRt = 9; s.ifidUsesRt = 0;
    applyStimulus(s);
    checkOutput("rt_unused_pc_enable", pcEn, 1);
    nextEdge();
    s.ifidUsesRt = 1;
    applyStimulus(s);
    checkOutput("rt_used_pc_enable", pcEn, 0);
    nextEdge();
    checkOutput("rt_used_stall_cnt", stallCnt, 2);
    applyStimulus(idleStim());
    nextEdge();

    s = lw8; s.branchTaken = 1;
    applyStimulus(s);
    checkOutput("br_ifid_flush", ifidFlush, 1);
    checkOutput("br_idex_flush", idexFlush, 1);
    checkOutput("br_pc_enable", pcEn, 1);
    nextEdge();
    checkOutput("br_flush_cnt", flushCnt, 1);
    checkOutput("br_stall_cnt", stallCnt, 2);
    checkOutput("br_state", state, 0);

    s = idleStim(); s.countersClr = 1;
    applyStimulus(s);
    nextEdge();
    checkOutput("clr_stall_cnt", stallCnt, 0);
    checkOutput("clr_flush_cnt", flushCnt, 0);

    s = idleStim(); s.memBusy = 1; s.jmp = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(s);
      checkOutput("frz_pc_enable", pcEn, 0);
      checkOutput("frz_ifid_enable", ifidEn, 0);
      checkOutput("frz_ifid_flush", ifidFlush, 0);
      checkOutput("frz_idex_flush", idexFlush, 0);
      nextEdge();
      checkOutput("frz_state", state, 2);
    end
    s.memBusy = 0;
    applyStimulus(s);
    checkOutput("unfrz_ifid_flush", ifidFlush, 1);
    checkOutput("unfrz_idex_flush", idexFlush, 1);
    nextEdge();
    checkOutput("unfrz_flush_cnt", flushCnt, 1);
    checkOutput("unfrz_state", state, 0);

    s = idleStim();
    s.exmemRw = 1; s.exmemWr = 5; s.memwbRw = 1; s.memwbWr = 5;
    s.idexRs = 5; s.idexRt = 5;
    applyStimulus(s);
    checkOutput("fwd_both_a", fwdA, 2);
    checkOutput("fwd_both_b", fwdB, 2);
    nextEdge();
    s.exmemRw = 0;
    applyStimulus(s);
    checkOutput("fwd_wb_a", fwdA, 1);
    checkOutput("fwd_wb_b", fwdB, 1);
    nextEdge();
    s = idleStim();
    s.exmemRw = 1; s.memwbRw = 1; s.exmemWr = 0; s.memwbWr = 0;
    applyStimulus(s);
    checkOutput("fwd_r0_a", fwdA, 0);
    checkOutput("fwd_r0_b", fwdB, 0);
    nextEdge();

    applyStimulus(lw8);
    nextEdge();
    checkOutput("flt_err_first", hazErr, 0);
    applyStimulus(lw8);
    nextEdge();
    checkOutput("flt_err_second", hazErr, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(lw8);
      nextEdge();
    end
    checkOutput("sat_stall_cnt2", sStallCnt, 3);
    checkOutput("sat_stall_cnt16", stallCnt, 5);
    s = lw8; s.countersClr = 1;
    applyStimulus(s);
    nextEdge();
    checkOutput("clr_over_stall_sat", sStallCnt, 0);
    checkOutput("clr_over_stall_16", stallCnt, 0);
    applyStimulus(idleStim());
    nextEdge();
    checkOutput("err_sticky", hazErr, 1);

    applyStimulus(lw8);
    nextEdge();
    checkOutput("pre_rst_state", state, 1);
    reset = 1'b0;
    #1;
    checkOutput("async_rst_state", state, 0);
    checkOutput("async_rst_err", hazErr, 0);
    checkOutput("async_rst_pc_enable", pcEn, 0);
    nextEdge();
    reset = 1'b1;
    applyStimulus(idleStim());
    nextEdge();
    checkOutput("post_rst_state", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
